rx_pixel_framer: RTL

Pixel framer between the UART receiver and the Sobel stage. It takes the one-cycle byte strobes from `uart_rx` and assigns each byte a column/row position inside an `IMG_W`×`IMG_H` frame. It can optionally convert RGB332 bytes to 8-bit luminance, and it emits start-of-frame, end-of-line and end-of-frame markers. A gap timeout aborts a stalled frame so that a dropped byte cannot shift every later frame.

---
 rtl/edge_pkg.sv | 17 +
 rtl/rgb332_to_gray.sv | 21 ++
 rtl/rx_pixel_framer.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the edge-detection pipeline: framer FSM states, grey
// coefficients and default frame geometry so the Sobel line buffers agree.
package edge_pkg;

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } fsm_state_e;

    localparam logic [15:0] GRAY_KR = 16'd77;
    localparam logic [15:0] GRAY_KG = 16'd150;
    localparam logic [15:0] GRAY_KB = 16'd29;

    localparam int IMG_W_DEF = 100;
    localparam int IMG_H_DEF = 100;

endpackage

// File: rtl/rgb332_to_gray.sv
// Combinational RGB332 to 8-bit luminance: channels widened by bit replication,
// then Y = (77*R + 150*G + 29*B) >> 8. Coefficients sum to 256, so no clipping.
module rgb332_to_gray
    import edge_pkg::*;
(
    input  logic [7:0] rgb_in,
    output logic [7:0] gray_out
);

    logic [7:0]  r8, g8, b8;
    logic [15:0] y_sum;

    always_comb begin
        r8       = {rgb_in[7:5], rgb_in[7:5], rgb_in[7:6]};
        g8       = {rgb_in[4:2], rgb_in[4:2], rgb_in[4:3]};
        b8       = {rgb_in[1:0], rgb_in[1:0], rgb_in[1:0], rgb_in[1:0]};
        y_sum    = GRAY_KR * {8'd0, r8} + GRAY_KG * {8'd0, g8} + GRAY_KB * {8'd0, b8};
        gray_out = y_sum[15:8];
    end

endmodule

// File: rtl/rx_pixel_framer.sv
// Assigns each received byte a column/row inside an IMG_W x IMG_H frame and
// aborts stalled frames. Define RX_PIXEL_FRAMER_GRAY_EN to convert RGB332 to grey.
module rx_pixel_framer
    import edge_pkg::*;
#(
    parameter int IMG_W       = IMG_W_DEF,
    parameter int IMG_H       = IMG_H_DEF,
    parameter int TIMEOUT_CYC = 200000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic [7:0] data_in,
    input  logic       in_flag,
    output logic [7:0] data_out,
    output logic       out_flag,
    output logic [9:0] pix_col,
    output logic [9:0] pix_row,
    output logic       sof,
    output logic       eol,
    output logic       eof,
    output logic       timeout_err,
    output logic [7:0] frame_cnt,
    output logic [7:0] err_cnt
);

    localparam int               GAP_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [9:0]       LAST_COL = 10'(IMG_W - 1);
    localparam logic [9:0]       LAST_ROW = 10'(IMG_H - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);

    logic [7:0] pix_byte;

`ifdef RX_PIXEL_FRAMER_GRAY_EN
    rgb332_to_gray u_gray (
        .rgb_in   (data_in),
        .gray_out (pix_byte)
    );
`else
    assign pix_byte = data_in;
`endif

    fsm_state_e       state_q, state_d;
    logic [9:0]       col_cnt_q, col_cnt_d, row_cnt_q, row_cnt_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic [7:0]       data_out_q, data_out_d;
    logic             out_flag_q, out_flag_d;
    logic [9:0]       pix_col_q, pix_col_d, pix_row_q, pix_row_d;
    logic             sof_q, sof_d, eol_q, eol_d, eof_q, eof_d;
    logic             timeout_err_q, timeout_err_d;
    logic [7:0]       frame_cnt_q, frame_cnt_d, err_cnt_q, err_cnt_d;
    logic             at_eol, at_eof;

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_d       = state_q;
        col_cnt_d     = col_cnt_q;
        row_cnt_d     = row_cnt_q;
        gap_d         = gap_q;
        data_out_d    = data_out_q;
        out_flag_d    = 1'b0;
        pix_col_d     = 10'd0;
        pix_row_d     = 10'd0;
        sof_d         = 1'b0;
        eol_d         = 1'b0;
        eof_d         = 1'b0;
        timeout_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        err_cnt_d     = err_cnt_q;
        at_eol        = (col_cnt_q == LAST_COL);
        at_eof        = at_eol && (row_cnt_q == LAST_ROW);

        // A byte always wins over a timeout landing on the same cycle.
        if (in_flag) begin
            out_flag_d = 1'b1;
            data_out_d = pix_byte;
            pix_col_d  = col_cnt_q;
            pix_row_d  = row_cnt_q;
            sof_d      = (state_q == IDLE);
            eol_d      = at_eol;
            eof_d      = at_eof;
            gap_d      = '0;
            if (at_eof) begin
                state_d     = IDLE;
                col_cnt_d   = 10'd0;
                row_cnt_d   = 10'd0;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end else begin
                state_d = ACTIVE;
                if (at_eol) begin
                    col_cnt_d = 10'd0;
                    row_cnt_d = row_cnt_q + 10'd1;
                end else begin
                    col_cnt_d = col_cnt_q + 10'd1;
                end
            end
        end else if (state_q == ACTIVE) begin
            if (gap_q == GAP_LAST) begin
                timeout_err_d = 1'b1;
                err_cnt_d     = (err_cnt_q == 8'hFF) ? err_cnt_q : err_cnt_q + 8'd1;
                col_cnt_d     = 10'd0;
                row_cnt_d     = 10'd0;
                gap_d         = '0;
                state_d       = IDLE;
            end else begin
                gap_d = gap_q + GAP_W'(1);
            end
        end else begin
            gap_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q       <= IDLE;
            col_cnt_q     <= 10'd0;
            row_cnt_q     <= 10'd0;
            gap_q         <= '0;
            data_out_q    <= 8'd0;
            out_flag_q    <= 1'b0;
            pix_col_q     <= 10'd0;
            pix_row_q     <= 10'd0;
            sof_q         <= 1'b0;
            eol_q         <= 1'b0;
            eof_q         <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= 8'd0;
            err_cnt_q     <= 8'd0;
        end else begin
            state_q       <= state_d;
            col_cnt_q     <= col_cnt_d;
            row_cnt_q     <= row_cnt_d;
            gap_q         <= gap_d;
            data_out_q    <= data_out_d;
            out_flag_q    <= out_flag_d;
            pix_col_q     <= pix_col_d;
            pix_row_q     <= pix_row_d;
            sof_q         <= sof_d;
            eol_q         <= eol_d;
            eof_q         <= eof_d;
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign data_out    = data_out_q;
    assign out_flag    = out_flag_q;
    assign pix_col     = pix_col_q;
    assign pix_row     = pix_row_q;
    assign sof         = sof_q;
    assign eol         = eol_q;
    assign eof         = eof_q;
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;
    assign err_cnt     = err_cnt_q;

endmodule
